// File: rtl/sniffer_fifo.sv
// Parametrised synchronous FIFO for sniffer capture words: FWFT or standard read mode,
// almost flags, occupancy count and sticky errors. `FIFO_FILL_STATS_EN adds max_count/drop_cnt.
module sniffer_fifo #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned FWFT      = 1,
    parameter int unsigned AFULL_TH  = DEPTH - 4,
    parameter int unsigned AEMPTY_TH = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      din,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      dout,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow,
    output logic [1:0]             err_sticky
`ifdef FIFO_FILL_STATS_EN
    ,
    output logic [$clog2(DEPTH):0] max_count,
    output logic [15:0]            drop_cnt
`endif
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_dout;
    logic              r_empty;
    logic              r_full;
    logic              r_afull;
    logic              r_aempty;
    logic              r_overflow;
    logic              r_underflow;
    logic [1:0]        r_err;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_wr_rej;
    logic              w_rd_rej;
    logic [CNT_W-1:0]  w_cnt_nxt;

    assign w_wr_acc  = wr_en && !r_full;
    assign w_rd_acc  = rd_en && !r_empty;
    assign w_wr_rej  = wr_en && r_full;
    assign w_rd_rej  = rd_en && r_empty;
    assign w_cnt_nxt = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);

    // Occupancy, flags, write pointer and error reporting (shared by both read modes)
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_err       <= 2'b00;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            r_count     <= w_cnt_nxt;
            r_full      <= (w_cnt_nxt == CNT_W'(DEPTH));
            r_afull     <= (w_cnt_nxt >= CNT_W'(AFULL_TH));
            r_aempty    <= (w_cnt_nxt <= CNT_W'(AEMPTY_TH));
            r_overflow  <= w_wr_rej;
            r_underflow <= w_rd_rej;
            r_err       <= r_err | {w_wr_rej, w_rd_rej};
        end
    end

    // Storage array: no reset, synchronous read in the mode-specific logic below
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Two-stage prefetch: RAM read register, then the visible output register.
            // count covers both stages, so words still in the array = count - staged words.
            logic [DATA_W-1:0] r_ram_q;
            logic              r_ram_vld;
            logic [CNT_W-1:0]  w_mem_words;
            logic              w_out_ld;
            logic              w_ram_ld;

            assign w_mem_words = r_count - CNT_W'(r_ram_vld) - CNT_W'(!r_empty);
            assign w_out_ld    = r_ram_vld && (r_empty || w_rd_acc);
            assign w_ram_ld    = (w_mem_words != '0) && (!r_ram_vld || w_out_ld);

            always_ff @(posedge clk) begin
                if (w_ram_ld) begin
                    r_ram_q <= r_mem[r_rd_ptr];
                end
            end

            always_ff @(posedge clk or posedge srst) begin
                if (srst) begin
                    r_rd_ptr  <= '0;
                    r_ram_vld <= 1'b0;
                    r_empty   <= 1'b1;
                    r_dout    <= '0;
                end else begin
                    if (w_ram_ld) begin
                        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                    end
                    r_ram_vld <= w_ram_ld || (r_ram_vld && !w_out_ld);
                    if (w_out_ld) begin
                        r_dout <= r_ram_q;
                    end
                    r_empty <= !(w_out_ld || (!r_empty && !w_rd_acc));
                end
            end
        end else begin : g_std
            // Standard mode: the popped word lands in dout on the accepting edge
            always_ff @(posedge clk or posedge srst) begin
                if (srst) begin
                    r_rd_ptr <= '0;
                    r_dout   <= '0;
                    r_empty  <= 1'b1;
                end else begin
                    if (w_rd_acc) begin
                        r_dout   <= r_mem[r_rd_ptr];
                        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                    end
                    r_empty <= (w_cnt_nxt == '0);
                end
            end
        end
    endgenerate

`ifdef FIFO_FILL_STATS_EN
    logic [CNT_W-1:0] r_max_count;
    logic [15:0]      r_drop_cnt;

    // High-water mark and saturating rejected-write counter
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_max_count <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_cnt_nxt > r_max_count) begin
                r_max_count <= w_cnt_nxt;
            end
            if (w_wr_rej && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign max_count = r_max_count;
    assign drop_cnt  = r_drop_cnt;
`endif

    assign dout         = r_dout;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign err_sticky   = r_err;

endmodule

// File: tb/tb_sniffer_fifo.sv
// Bench for sniffer_fifo: an FWFT and a standard-mode instance (DEPTH=8) share stimulus and
// are each checked every cycle against a queue-based reference model.
module tb_sniffer_fifo;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFT   = 6;
    localparam int unsigned AET   = 1;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          srst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rd_en = 1'b0;

    logic [DW-1:0] f_dout, s_dout;
    logic          f_full, s_full, f_empty, s_empty;
    logic          f_afull, s_afull, f_aempty, s_aempty;
    logic [CW-1:0] f_count, s_count;
    logic          f_ovf, s_ovf, f_udf, s_udf;
    logic [1:0]    f_err, s_err;
`ifdef FIFO_FILL_STATS_EN
    logic [CW-1:0] f_max, s_max;
    logic [15:0]   f_drop, s_drop;
`endif

    always #5 clk = ~clk;

    sniffer_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1), .AFULL_TH(AFT), .AEMPTY_TH(AET)) u_fwft (
        .clk(clk), .srst(srst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(f_dout),
        .full(f_full), .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
        .count(f_count), .overflow(f_ovf), .underflow(f_udf), .err_sticky(f_err)
`ifdef FIFO_FILL_STATS_EN
        , .max_count(f_max), .drop_cnt(f_drop)
`endif
    );

    sniffer_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0), .AFULL_TH(AFT), .AEMPTY_TH(AET)) u_std (
        .clk(clk), .srst(srst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(s_dout),
        .full(s_full), .empty(s_empty), .almost_full(s_afull), .almost_empty(s_aempty),
        .count(s_count), .overflow(s_ovf), .underflow(s_udf), .err_sticky(s_err)
`ifdef FIFO_FILL_STATS_EN
        , .max_count(s_max), .drop_cnt(s_drop)
`endif
    );

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    longint      edge_n   = 0;
    string       phase    = "init";

    // FWFT model: words with their write edge; a head word is visible two edges after its write
    logic [DW-1:0] fq_d[$];
    longint        fq_w[$];
    logic [DW-1:0] fm_dout;
    bit            fm_ovf, fm_udf;
    logic [1:0]    fm_err;
    int            fm_max, fm_drop;

    // Standard-mode model
    logic [DW-1:0] sq[$];
    logic [DW-1:0] sm_dout;
    bit            sm_ovf, sm_udf;
    logic [1:0]    sm_err;
    int            sm_max, sm_drop;

    function automatic bit f_vis(input longint e);
        return (fq_d.size() > 0) && (e >= fq_w[0] + 2);
    endfunction

    task automatic model_reset();
        fq_d.delete(); fq_w.delete(); sq.delete();
        fm_dout = '0; fm_ovf = 0; fm_udf = 0; fm_err = 2'b00; fm_max = 0; fm_drop = 0;
        sm_dout = '0; sm_ovf = 0; sm_udf = 0; sm_err = 2'b00; sm_max = 0; sm_drop = 0;
    endtask

    task automatic model_edge(input bit we, input logic [DW-1:0] d, input bit re);
        bit vis, rd_acc, wr_acc;
        vis    = f_vis(edge_n - 1);
        rd_acc = re && vis;
        wr_acc = we && (fq_d.size() < DEPTH);
        fm_ovf = we && !wr_acc;
        fm_udf = re && !vis;
        fm_err = fm_err | {fm_ovf, fm_udf};
        if (fm_ovf && fm_drop < 65535) fm_drop++;
        if (rd_acc) begin
            void'(fq_d.pop_front());
            void'(fq_w.pop_front());
        end
        if (wr_acc) begin
            fq_d.push_back(d);
            fq_w.push_back(edge_n);
        end
        if (f_vis(edge_n)) fm_dout = fq_d[0];
        if (fq_d.size() > fm_max) fm_max = fq_d.size();

        rd_acc = re && (sq.size() > 0);
        wr_acc = we && (sq.size() < DEPTH);
        sm_ovf = we && !wr_acc;
        sm_udf = re && !rd_acc;
        sm_err = sm_err | {sm_ovf, sm_udf};
        if (sm_ovf && sm_drop < 65535) sm_drop++;
        if (rd_acc) sm_dout = sq.pop_front();
        if (wr_acc) sq.push_back(d);
        if (sq.size() > sm_max) sm_max = sq.size();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk({phase, ".f.dout"},   64'(f_dout),   64'(fm_dout));
        chk({phase, ".f.empty"},  64'(f_empty),  64'(!f_vis(edge_n)));
        chk({phase, ".f.full"},   64'(f_full),   64'(fq_d.size() == DEPTH));
        chk({phase, ".f.afull"},  64'(f_afull),  64'(fq_d.size() >= AFT));
        chk({phase, ".f.aempty"}, 64'(f_aempty), 64'(fq_d.size() <= AET));
        chk({phase, ".f.count"},  64'(f_count),  64'(fq_d.size()));
        chk({phase, ".f.ovf"},    64'(f_ovf),    64'(fm_ovf));
        chk({phase, ".f.udf"},    64'(f_udf),    64'(fm_udf));
        chk({phase, ".f.err"},    64'(f_err),    64'(fm_err));
        chk({phase, ".s.dout"},   64'(s_dout),   64'(sm_dout));
        chk({phase, ".s.empty"},  64'(s_empty),  64'(sq.size() == 0));
        chk({phase, ".s.full"},   64'(s_full),   64'(sq.size() == DEPTH));
        chk({phase, ".s.afull"},  64'(s_afull),  64'(sq.size() >= AFT));
        chk({phase, ".s.aempty"}, 64'(s_aempty), 64'(sq.size() <= AET));
        chk({phase, ".s.count"},  64'(s_count),  64'(sq.size()));
        chk({phase, ".s.ovf"},    64'(s_ovf),    64'(sm_ovf));
        chk({phase, ".s.udf"},    64'(s_udf),    64'(sm_udf));
        chk({phase, ".s.err"},    64'(s_err),    64'(sm_err));
`ifdef FIFO_FILL_STATS_EN
        chk({phase, ".f.max"},  64'(f_max),  64'(fm_max));
        chk({phase, ".f.drop"}, 64'(f_drop), 64'(fm_drop));
        chk({phase, ".s.max"},  64'(s_max),  64'(sm_max));
        chk({phase, ".s.drop"}, 64'(s_drop), 64'(sm_drop));
`endif
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 time unit later
    task automatic step(input bit we, input logic [DW-1:0] d, input bit re);
        wr_en = we; din = d; rd_en = re;
        @(posedge clk);
        edge_n++;
        if (srst) model_reset();
        else model_edge(we, d, re);
        #1;
        check_all();
    endtask

    // Asynchronous reset between edges with inputs left as they were
    task automatic do_reset();
        #2;
        srst = 1'b1;
        #1;
        model_reset();
        check_all();
        step(1'b0, '0, 1'b0);
        srst = 1'b0;
        step(1'b0, '0, 1'b0);
    endtask

    initial begin
        int pct_w[4];
        int pct_r[4];
        pct_w[0] = 70; pct_w[1] = 30; pct_w[2] = 55; pct_w[3] = 90;
        pct_r[0] = 40; pct_r[1] = 75; pct_r[2] = 55; pct_r[3] = 85;

        model_reset();
        phase = "reset";
        do_reset();

        phase = "single";
        step(1'b1, 16'h00A5, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        phase = "fill";
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b1, 16'h00FF, 1'b0);
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        phase = "wrap";
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        phase = "udf";
        do_reset();
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b1, 16'h003C, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        phase = "thresh";
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, DW'(16'h100 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        phase = "midrst";
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h200 + i), 1'b0);
        do_reset();
        step(1'b1, 16'h0077, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        phase = "random";
        do_reset();
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 99) < pct_w[seg], DW'($urandom),
                     $urandom_range(0, 99) < pct_r[seg]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sniffer_fifo.md
Name: sniffer_fifo

Overview:
- Parametrised synchronous FIFO with native write/read handshake (wr_en/full, rd_en/empty), implemented in plain RTL with no vendor IP.
- Buffers captured sniffer words between the capture front-end and the DMA/readout side.
- Adds configurable width and depth, first-word-fall-through (FWFT) or standard read mode, programmable almost-full/almost-empty flags, an occupancy count and sticky error flags.

Parameters:
- DATA_W, 64, data word width in bits.
- DEPTH, 512, number of entries; must be a power of two and at least 4.
- FWFT, 1, 1 = first-word-fall-through read mode, 0 = standard read mode (registered dout after rd_en).
- AFULL_TH, DEPTH-4, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 4, almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  in  1  single clock for the whole block.
- srst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request.
- din  in  DATA_W  write data.
- rd_en  in  1  read request / pop.
- dout  out  DATA_W  read data.
- full  out  1  no free entry.
- empty  out  1  no readable word.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  $clog2(DEPTH)+1  stored words.
- overflow  out  1  one-cycle pulse when a write is rejected.
- underflow  out  1  one-cycle pulse when a read is rejected.
- err_sticky  out  2  {overflow seen, underflow seen}; cleared only by srst.

Behaviour:
- Reset: srst=1 clears pointers and count immediately (async) and holds them cleared.
  - Reset values: empty=1, full=0, almost_empty=1, almost_full=0, count=0, dout=0, overflow=0, underflow=0, err_sticky=0.
  - Mid-operation reset discards all contents; the first write after release behaves as a write into an empty FIFO.
- Write accepted iff wr_en && !full; din is stored at wr_ptr and wr_ptr increments modulo DEPTH (wraps naturally, ADDR_W=$clog2(DEPTH)).
- Read accepted iff rd_en && !empty; rd_ptr increments modulo DEPTH.
- Rejected writes and reads:
  - wr_en && full: write dropped, overflow=1 for one cycle, err_sticky[1] set.
  - rd_en && empty: no pointer change, underflow=1 for one cycle, err_sticky[0] set.
- count, full, empty and the almost flags are all registered and updated on the edge that accepts the operation.
  - Accepted write only: count+1. Accepted read only: count-1. Both accepted: count unchanged.
  - full = (count==DEPTH). empty is defined per mode below.
- Simultaneous events:
  - wr_en && rd_en while empty: write accepted, read rejected (underflow pulse); no pass-through.
  - wr_en && rd_en while full: read accepted, write rejected (overflow pulse).
- Standard mode (FWFT=0):
  - empty = (count==0).
  - dout updates one cycle after an accepted read with the popped word; it holds its value otherwise.
  - Write-to-empty-deassert latency is 1 cycle.
- FWFT mode (FWFT=1):
  - Output register holds the head word; empty=0 means dout is valid now.
  - rd_en pops the head, and the next word (or empty=1) appears on the following cycle.
  - First write into an empty FIFO: dout valid and empty=0 two cycles after the write edge (memory read, then output register).
  - count includes the word held in the output register; full still means count==DEPTH.
  - Back-to-back rd_en with data available sustains 1 word/cycle.
- Memory is inferred as simple dual-port RAM with a synchronous read port; no reset on the array.

Optional Feature:
- Macro FIFO_FILL_STATS_EN.
- Defined:
  - Adds output port max_count (width $clog2(DEPTH)+1): a high-water mark that updates to count whenever count exceeds it; reset to 0 by srst.
  - Adds output port drop_cnt (16 bits): counts rejected writes, saturating at 16'hFFFF.
- Undefined: neither port exists and no related logic is synthesised.

Test Plan:
- Reset release, FWFT=1, DEPTH=8: write 0xA5 once -> empty=0 and dout=0xA5 two cycles after the write edge; count=1.
- Fill DEPTH=8 with 0..7, then one extra write of 0xFF -> full=1 at count=8; overflow pulses 1 cycle; err_sticky=2'b10; draining yields 0..7 with no 0xFF.
- Continuous wr_en+rd_en for 20 cycles with count=3, crossing wrap-around -> count stays 3; output order is preserved across the pointer wrap.
- rd_en while empty (FWFT=0) -> underflow pulses 1 cycle; dout unchanged; err_sticky=2'b01; pointers unchanged.
- AFULL_TH=6, AEMPTY_TH=1: fill to 6 -> almost_full=1 on the 6th write edge; drain to 1 -> almost_empty=1.
- srst asserted mid-burst at count=5 -> all outputs go to reset values asynchronously; after release, a new write reads back correctly. With FIFO_FILL_STATS_EN defined: max_count=0 after reset.
